product_serializer: RTL and testbench
=====================================

PRODUCT_SERIALIZER -- requirements
Module: product_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of each product field.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port ASYNCRESET, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port I_valid, input, 1 bit, meaning the upstream product {I_x, I_y} is valid.
REQ-005 The block SHALL have port I_ready, output, 1 bit, meaning the block accepts the product this cycle.
REQ-006 The block SHALL have ports I_x and I_y, input, WIDTH bits each, carrying the product fields.
REQ-007 The block SHALL have port O_valid, output, 1 bit, meaning the current output beat is valid.
REQ-008 The block SHALL have port O_ready, input, 1 bit, meaning downstream takes the beat.
REQ-009 The block SHALL have port O_data, output, WIDTH bits, carrying the current field value.
REQ-010 The block SHALL have port O_sel, output, 1 bit, where 0 means field x and 1 means field y.
REQ-011 The block SHALL have port O_last, output, 1 bit, asserted on the final beat (y) of each product.
REQ-012 The block SHALL have port O_count, output, 16 bits, counting products fully sent.

Function
REQ-013 The FSM SHALL have states IDLE, SEND_X and SEND_Y, held in a registered state variable.
REQ-014 An input transfer SHALL occur when I_valid and I_ready are both high, capturing I_x and I_y into hold registers.
REQ-015 I_ready SHALL equal (state==IDLE) OR (state==SEND_Y AND O_ready), combinationally.
REQ-016 On an input transfer from IDLE, the state SHALL become SEND_X; latency from accept to O_valid SHALL be one cycle.
REQ-017 In SEND_X the outputs SHALL be O_valid=1, O_data=x_hold, O_sel=0, O_last=0; on O_ready the state SHALL become SEND_Y.
REQ-018 In SEND_Y the outputs SHALL be O_valid=1, O_data=y_hold, O_sel=1, O_last=1.
REQ-019 In SEND_Y with O_ready high, the state SHALL become SEND_X if an input transfer occurs in the same cycle, else IDLE.
REQ-020 In IDLE, O_valid SHALL be 0 and O_data, O_sel and O_last SHALL be 0.
REQ-021 While O_valid=1 and O_ready=0, O_data, O_sel and O_last SHALL hold stable and the hold registers SHALL NOT change.
REQ-022 Sustained throughput SHALL be one product per two cycles, with no bubble between back-to-back products.
REQ-023 O_count SHALL increment by 1 on each SEND_Y beat transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 Upstream changes to I_x or I_y while I_ready=0 SHALL have no effect on the output.

Reset
REQ-025 While ASYNCRESET=1, the state SHALL be IDLE, the hold registers 0, O_count 0, O_valid 0, O_data 0, O_sel 0, O_last 0 and I_ready 0; I_ready SHALL be 0 for the whole time reset is asserted, regardless of REQ-015.
REQ-026 Reset asserted mid-product SHALL drop the in-flight product without emitting its remaining beats.
REQ-027 After ASYNCRESET deasserts, I_ready SHALL be 1 in the first CLK cycle.

Configuration
REQ-028 With macro PRODUCT_SERIALIZER_PARITY_EN defined, the block SHALL add output O_parity, 1 bit, equal to the XOR reduction of O_data, and 0 in IDLE and during reset.
REQ-029 Without PRODUCT_SERIALIZER_PARITY_EN, the O_parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 The package product_serializer_pkg SHALL define the state enum (IDLE, SEND_X, SEND_Y), the field-select constants SEL_X=0 and SEL_Y=1, and COUNT_W=16.
REQ-031 The block SHALL contain one sub-module, product_hold_reg, holding x/y with a load enable and asynchronous clear; the FSM and counter SHALL stay in the top.

Verification
REQ-032 WIDTH=8; from reset, present x=0x5A, y=0xC3 with O_ready=1 -> beats (0x5A, sel 0, last 0) then (0xC3, sel 1, last 1) on consecutive cycles; O_count=1.
REQ-033 Back-to-back: I_valid held high with products (0x01,0x02), (0x03,0x04) and O_ready=1 -> four consecutive beats 01,02,03,04 with no gap; I_ready high only in IDLE and SEND_Y cycles.
REQ-034 Backpressure: O_ready=0 for 5 cycles during SEND_X while I_x/I_y toggle -> O_data stays 0x5A and I_ready=0 throughout.
REQ-035 ASYNCRESET pulsed while in SEND_Y -> O_valid drops immediately, no y beat is emitted, O_count stays 0, and I_ready=1 in the first cycle after release.
REQ-036 Preload O_count to 0xFFFF (force) and send one product -> O_count=0x0000.
REQ-037 With PRODUCT_SERIALIZER_PARITY_EN, x=0x07 and y=0x03 -> O_parity=1 on the x beat and 0 on the y beat.

Source files
------------

// File: rtl/product_serializer_pkg.sv
// rtl/product_serializer_pkg.sv - shared types and constants for the product serializer
package product_serializer_pkg;

    localparam int COUNT_W = 16;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_X = 2'd1,
        SEND_Y = 2'd2
    } state_e;

endpackage

// File: rtl/product_serializer_if.sv
// rtl/product_serializer_if.sv - product-in / beat-out handshake bundle
// Optional O_parity signal exists only with PRODUCT_SERIALIZER_PARITY_EN.
interface product_serializer_if #(
    parameter int WIDTH = 8
);
    import product_serializer_pkg::*;

    logic               I_valid;
    logic               I_ready;
    logic [WIDTH-1:0]   I_x;
    logic [WIDTH-1:0]   I_y;
    logic               O_valid;
    logic               O_ready;
    logic [WIDTH-1:0]   O_data;
    logic               O_sel;
    logic               O_last;
    logic [COUNT_W-1:0] O_count;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    logic               O_parity;

    modport master (
        output I_valid, I_x, I_y, O_ready,
        input  I_ready, O_valid, O_data, O_sel, O_last, O_count, O_parity
    );
    modport slave (
        input  I_valid, I_x, I_y, O_ready,
        output I_ready, O_valid, O_data, O_sel, O_last, O_count, O_parity
    );
`else
    modport master (
        output I_valid, I_x, I_y, O_ready,
        input  I_ready, O_valid, O_data, O_sel, O_last, O_count
    );
    modport slave (
        input  I_valid, I_x, I_y, O_ready,
        output I_ready, O_valid, O_data, O_sel, O_last, O_count
    );
`endif

endinterface

// File: rtl/product_serializer_hold_reg.sv
// rtl/product_serializer_hold_reg.sv - x/y capture registers with load enable and async clear
module product_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_load) begin
            r_x <= i_x;
            r_y <= i_y;
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/product_serializer.sv
// rtl/product_serializer.sv - splits each {x,y} product into two output beats
// Optional O_parity output enabled by PRODUCT_SERIALIZER_PARITY_EN.
module product_serializer
    import product_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    product_serializer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SEND_X = SEND_X;
    localparam logic [1:0] ST_SEND_Y = SEND_Y;

    logic [1:0]         r_state;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]   w_x_hold;
    logic [WIDTH-1:0]   w_y_hold;
    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_y_done;
    logic               w_valid;
    logic [WIDTH-1:0]   w_data;
    logic               w_sel;
    logic               w_last;

    // Reset gates ready directly so nothing is accepted while it is held.
    assign w_in_ready = !ASYNCRESET &&
                        ((r_state == ST_IDLE) || ((r_state == ST_SEND_Y) && bus.O_ready));
    assign w_in_xfer  = bus.I_valid && w_in_ready;
    assign w_y_done   = (r_state == ST_SEND_Y) && bus.O_ready;

    product_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .i_clk  (CLK),
        .i_rst  (ASYNCRESET),
        .i_load (w_in_xfer),
        .i_x    (bus.I_x),
        .i_y    (bus.I_y),
        .o_x    (w_x_hold),
        .o_y    (w_y_hold)
    );

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_in_xfer) r_state <= ST_SEND_X;
                ST_SEND_X: if (bus.O_ready) r_state <= ST_SEND_Y;
                ST_SEND_Y: if (bus.O_ready) r_state <= w_in_xfer ? ST_SEND_X : ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_count <= '0;
        end else if (w_y_done) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_valid = 1'b0;
        w_data  = '0;
        w_sel   = SEL_X;
        w_last  = 1'b0;
        case (r_state)
            ST_SEND_X: begin
                w_valid = 1'b1;
                w_data  = w_x_hold;
            end
            ST_SEND_Y: begin
                w_valid = 1'b1;
                w_data  = w_y_hold;
                w_sel   = SEL_Y;
                w_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.I_ready = w_in_ready;
    assign bus.O_valid = w_valid;
    assign bus.O_data  = w_data;
    assign bus.O_sel   = w_sel;
    assign bus.O_last  = w_last;
    assign bus.O_count = r_count;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    assign bus.O_parity = ^w_data;
`endif

endmodule

// File: tb/tb_product_serializer.sv
// tb/tb_product_serializer.sv - scoreboard bench for product_serializer
module tb_product_serializer;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sel;
        logic             last;
    } beat_t;

    logic  CLK = 1'b0;
    logic  ASYNCRESET = 1'b1;
    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    product_serializer_if #(.WIDTH(WIDTH)) ps_if ();

    product_serializer #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .bus        (ps_if)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic s, input logic l);
        beat_t b;
        b.data = d;
        b.sel  = s;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Monitor: every accepted output beat is matched against the scoreboard.
    always @(negedge CLK) begin
        if (!ASYNCRESET && ps_if.O_valid && ps_if.O_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {23'd0, ps_if.O_data, ps_if.O_sel}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat", {22'd0, ps_if.O_data, ps_if.O_sel, ps_if.O_last},
                              {22'd0, e.data, e.sel, e.last});
            end
`ifdef PRODUCT_SERIALIZER_PARITY_EN
            check("parity_track", {31'd0, ps_if.O_parity}, {31'd0, ^ps_if.O_data});
`endif
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ps_if.I_valid = 1'b0;
        ps_if.I_x     = '0;
        ps_if.I_y     = '0;
        ps_if.O_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_i_ready", {31'd0, ps_if.I_ready}, 32'd0);
        check("rst_o_valid", {31'd0, ps_if.O_valid}, 32'd0);
        check("rst_o_count", {16'd0, ps_if.O_count}, 32'd0);
        check("rst_o_fields", {22'd0, ps_if.O_data, ps_if.O_sel, ps_if.O_last}, 32'd0);
        ASYNCRESET = 1'b0;
        #1;
        check("post_rst_i_ready", {31'd0, ps_if.I_ready}, 32'd1);

        // Single product
        ps_if.I_valid = 1'b1; ps_if.I_x = 8'h5A; ps_if.I_y = 8'hC3;
        push(8'h5A, 1'b0, 1'b0);
        push(8'hC3, 1'b1, 1'b1);
        tick();
        ps_if.I_valid = 1'b0;
        check("latency_o_valid", {31'd0, ps_if.O_valid}, 32'd1);
        repeat (2) tick();
        check("single_count", {16'd0, ps_if.O_count}, 32'd1);
        check("idle_fields", {21'd0, ps_if.O_valid, ps_if.O_data, ps_if.O_sel, ps_if.O_last}, 32'd0);

        // Back-to-back products
        ps_if.I_valid = 1'b1; ps_if.I_x = 8'h01; ps_if.I_y = 8'h02;
        push(8'h01, 1'b0, 1'b0); push(8'h02, 1'b1, 1'b1);
        push(8'h03, 1'b0, 1'b0); push(8'h04, 1'b1, 1'b1);
        check("b2b_rdy_idle", {31'd0, ps_if.I_ready}, 32'd1);
        tick();
        ps_if.I_x = 8'h03; ps_if.I_y = 8'h04;
        check("b2b_c1", {30'd0, ps_if.O_valid, ps_if.I_ready}, 32'b10);
        tick();
        check("b2b_c2", {30'd0, ps_if.O_valid, ps_if.I_ready}, 32'b11);
        tick();
        ps_if.I_valid = 1'b0;
        check("b2b_c3", {30'd0, ps_if.O_valid, ps_if.I_ready}, 32'b10);
        tick();
        check("b2b_c4", {30'd0, ps_if.O_valid, ps_if.I_ready}, 32'b11);
        tick();
        check("b2b_count", {16'd0, ps_if.O_count}, 32'd3);

        // Backpressure in SEND_X with toggling upstream
        ps_if.O_ready = 1'b0;
        ps_if.I_valid = 1'b1; ps_if.I_x = 8'h5A; ps_if.I_y = 8'hC3;
        push(8'h5A, 1'b0, 1'b0); push(8'hC3, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            ps_if.I_x = ps_if.I_x ^ 8'hFF;
            ps_if.I_y = ps_if.I_y ^ 8'hFF;
            #1;
            check("bp_hold", {22'd0, ps_if.O_data, ps_if.O_sel, ps_if.I_ready}, {22'd0, 8'h5A, 2'b00});
            tick();
        end
        ps_if.I_valid = 1'b0;
        ps_if.O_ready = 1'b1;
        repeat (3) tick();
        check("bp_count", {16'd0, ps_if.O_count}, 32'd4);

        // Reset while in SEND_Y
        ps_if.O_ready = 1'b0;
        ps_if.I_valid = 1'b1; ps_if.I_x = 8'h66; ps_if.I_y = 8'h99;
        push(8'h66, 1'b0, 1'b0);
        tick();
        ps_if.I_valid = 1'b0;
        ps_if.O_ready = 1'b1;
        tick();
        ps_if.O_ready = 1'b0;
        check("sendy_before_rst", {31'd0, ps_if.O_last}, 32'd1);
        ASYNCRESET = 1'b1;
        #1;
        check("midrst_o_valid", {30'd0, ps_if.O_valid, ps_if.I_ready}, 32'd0);
        repeat (2) tick();
        ASYNCRESET = 1'b0;
        #1;
        check("midrst_release_rdy", {31'd0, ps_if.I_ready}, 32'd1);
        check("midrst_count", {16'd0, ps_if.O_count}, 32'd0);
        ps_if.O_ready = 1'b1;
        repeat (3) tick();

        // Counter wrap
        force dut.r_count = 16'hFFFF;
        tick();
        release dut.r_count;
        check("force_count", {16'd0, ps_if.O_count}, 32'h0000FFFF);
        ps_if.I_valid = 1'b1; ps_if.I_x = 8'h11; ps_if.I_y = 8'h22;
        push(8'h11, 1'b0, 1'b0); push(8'h22, 1'b1, 1'b1);
        tick();
        ps_if.I_valid = 1'b0;
        repeat (2) tick();
        check("wrap_count", {16'd0, ps_if.O_count}, 32'd0);

`ifdef PRODUCT_SERIALIZER_PARITY_EN
        check("parity_idle", {31'd0, ps_if.O_parity}, 32'd0);
        ps_if.I_valid = 1'b1; ps_if.I_x = 8'h07; ps_if.I_y = 8'h03;
        push(8'h07, 1'b0, 1'b0); push(8'h03, 1'b1, 1'b1);
        tick();
        ps_if.I_valid = 1'b0;
        check("parity_x", {31'd0, ps_if.O_parity}, 32'd1);
        tick();
        check("parity_y", {31'd0, ps_if.O_parity}, 32'd0);
        repeat (2) tick();
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
